adc_spi_responder: RTL and testbench

//  Responder side of the adc_go/adc_chan/adc_in/adc_valid handshake driven by the ADC auto-updater.
//  On a go request it runs one SPI frame on the external 10-bit serial ADC for the requested channel,

---
 rtl/adc_spi_responder.sv | 172 +++++++++++++++++
 tb/tb_adc_spi_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI front-end answering the ADC auto-updater go/valid handshake
//
// Purpose: on a rising edge of adc_go while idle, runs one mode-0 SPI frame on the external
// 10-bit serial ADC for the requested channel. The result comes back on adc_in with a
// one-cycle adc_valid pulse.
//
// Ports:
//   clk3p2M    in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   adc_go     in   1   conversion request, rising edge starts a frame
//   adc_chan   in   4   channel, captured when the frame starts
//   adc_in     out  10  last conversion result, changes only with adc_valid
//   adc_valid  out  1   one-cycle pulse, adc_in updated this cycle
//   adc_busy   out  1   frame in progress, through the adc_valid cycle
//   adc_cs_n   out  1   ADC chip select, active low
//   adc_sclk   out  1   SPI clock, idles low
//   adc_mosi   out  1   command bits to the ADC
//   adc_miso   in   1   result bits from the ADC
module adc_spi_responder #(
    parameter int SCLK_DIV    = 1,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_FIRST  = 6,
    parameter int CS_HIGH_CYC = 2
) (
    input  logic       clk3p2M,
    input  logic       reset_n,
    input  logic       adc_go,
    input  logic [3:0] adc_chan,
    output logic [9:0] adc_in,
    output logic       adc_valid,
    output logic       adc_busy,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_mosi,
    input  logic       adc_miso
);
    localparam int HW = $clog2(SCLK_DIV) + 1;
    localparam int BW = $clog2(FRAME_BITS) + 1;
    localparam int CW = $clog2(CS_HIGH_CYC) + 1;

    localparam logic [HW-1:0] H_LAST  = HW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CS_HIGH_CYC - 1);
    localparam logic [BW-1:0] D_FIRST = BW'(DATA_FIRST);
    localparam logic [BW-1:0] D_LAST  = BW'(DATA_FIRST + 9);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          go_d;
    logic [HW-1:0] hcnt;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] hold_cnt;
    logic          sclk_hi;
    logic [15:0]   cmd_sreg;
    logic [9:0]    sreg;

    logic start;
    logic half_end;
    logic in_window;

    assign start     = adc_go & ~go_d & (state == IDLE);
    assign half_end  = (hcnt == H_LAST);
    assign in_window = (bit_cnt >= D_FIRST) && (bit_cnt <= D_LAST);

    // State register
    always_ff @(posedge clk3p2M or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = CS_SETUP;
            CS_SETUP: if (half_end) state_nx = SHIFT;
            SHIFT:    if (half_end && sclk_hi && (bit_cnt == B_LAST)) state_nx = CS_HOLD;
            CS_HOLD:  if (hold_cnt == C_LAST) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Datapath: counters, command/result shift registers, result register
    always_ff @(posedge clk3p2M or negedge reset_n) begin
        if (!reset_n) begin
            // go_d resets high so a go level already present at reset release is not an edge
            go_d     <= 1'b1;
            hcnt     <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            sclk_hi  <= 1'b0;
            cmd_sreg <= '0;
            sreg     <= '0;
            adc_in   <= '0;
        end else begin
            go_d <= adc_go;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_sreg <= {2'b11, adc_chan, 10'b0};
                        hcnt     <= '0;
                        bit_cnt  <= '0;
                        hold_cnt <= '0;
                        sclk_hi  <= 1'b0;
                        sreg     <= '0;
                    end
                end
                CS_SETUP: begin
                    hcnt <= half_end ? '0 : hcnt + 1'b1;
                end
                SHIFT: begin
                    if (half_end) begin
                        hcnt    <= '0;
                        sclk_hi <= ~sclk_hi;
                        if (!sclk_hi) begin
                            // sclk about to rise: sample MISO if inside the result window
                            if (in_window) sreg <= {sreg[8:0], adc_miso};
                        end else begin
                            // sclk about to fall: advance to the next command bit
                            bit_cnt  <= bit_cnt + 1'b1;
                            cmd_sreg <= {cmd_sreg[14:0], 1'b0};
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    // loaded on entry to DONE so adc_in is new during the valid cycle
                    if (hold_cnt == C_LAST) adc_in <= sreg;
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        adc_cs_n  = 1'b1;
        adc_sclk  = 1'b0;
        adc_mosi  = 1'b0;
        adc_valid = 1'b0;
        adc_busy  = 1'b1;
        case (state)
            IDLE:     adc_busy = 1'b0;
            CS_SETUP: begin
                adc_cs_n = 1'b0;
                adc_mosi = cmd_sreg[15];
            end
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = sclk_hi;
                adc_mosi = cmd_sreg[15];
            end
            CS_HOLD:  ;
            DONE:     adc_valid = 1'b1;
            default:  adc_busy = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - bench for adc_spi_responder with serial ADC model
module tb_adc_spi_responder;
    localparam int SD     = 1;
    localparam int FB     = 16;
    localparam int DF     = 6;
    localparam int CH     = 2;
    localparam int LAT    = 1 + SD * (1 + 2 * FB) + CH;
    localparam int CS_LOW = SD * (1 + 2 * FB);
    localparam int SD3    = 3;
    localparam int LAT3   = 1 + SD3 * (1 + 2 * FB) + CH;

    logic       clk3p2M;
    logic       reset_n  = 1'b0;
    logic       adc_go   = 1'b0;
    logic [3:0] adc_chan = 4'd0;
    logic [9:0] adc_in;
    logic       adc_valid, adc_busy, adc_cs_n, adc_sclk, adc_mosi;
    logic       adc_miso = 1'b0;

    logic       go3   = 1'b0;
    logic [3:0] chan3 = 4'd0;
    logic [9:0] in3;
    logic       valid3, busy3, cs3, sclk3, mosi3;

    adc_spi_responder dut (
        .clk3p2M(clk3p2M), .reset_n(reset_n), .adc_go(adc_go), .adc_chan(adc_chan),
        .adc_in(adc_in), .adc_valid(adc_valid), .adc_busy(adc_busy), .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso)
    );

    adc_spi_responder #(.SCLK_DIV(SD3)) dut3 (
        .clk3p2M(clk3p2M), .reset_n(reset_n), .adc_go(go3), .adc_chan(chan3),
        .adc_in(in3), .adc_valid(valid3), .adc_busy(busy3), .adc_cs_n(cs3),
        .adc_sclk(sclk3), .adc_mosi(mosi3), .adc_miso(1'b1)
    );

    initial begin
        clk3p2M = 1'b0;
        forever #156 clk3p2M = ~clk3p2M;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: result bit 9 is presented for SCLK rising edge DF, bit 0 for edge DF+9;
    // every other edge sees random junk that must be discarded.
    logic [9:0] adc_result = 10'd0;

    function automatic logic miso_bit(input int k);
        if (k >= DF && k <= DF + 9) return adc_result[DF + 9 - k];
        return 1'($urandom);
    endfunction

    int          frame_cnt = 0, valid_cnt = 0, cs_low_tot = 0, in_bad = 0;
    int          gap_last = 0, cs_high_run = 0, edge_k = 0;
    logic [15:0] mosi_cap = 16'd0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [9:0]  prev_in = 10'd0;

    always @(negedge clk3p2M) begin
        prev_cs   <= adc_cs_n;
        prev_sclk <= adc_sclk;
        prev_in   <= adc_in;
        if (adc_valid) valid_cnt <= valid_cnt + 1;
        if (reset_n && (adc_in !== prev_in) && !adc_valid) in_bad <= in_bad + 1;
        if (adc_cs_n) cs_high_run <= cs_high_run + 1;
        else begin
            cs_high_run <= 0;
            cs_low_tot  <= cs_low_tot + 1;
        end
        if (prev_cs && !adc_cs_n) begin
            frame_cnt <= frame_cnt + 1;
            gap_last  <= cs_high_run;
            edge_k    <= 0;
            mosi_cap  <= 16'd0;
            adc_miso  <= miso_bit(0);
        end else if (!adc_cs_n && adc_sclk && !prev_sclk) begin
            mosi_cap <= {mosi_cap[14:0], adc_mosi};
            edge_k   <= edge_k + 1;
            adc_miso <= miso_bit(edge_k + 1);
        end
    end

    // SCLK_DIV=3 instance: SCLK run lengths, cs low cycles, valid pulses
    int   cs3_low_tot = 0, valid3_cnt = 0, run3 = 0, rises3 = 0;
    int   hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic prev_cs3 = 1'b1, prev_sclk3 = 1'b0;

    always @(negedge clk3p2M) begin
        prev_cs3   <= cs3;
        prev_sclk3 <= sclk3;
        if (!cs3) cs3_low_tot <= cs3_low_tot + 1;
        if (valid3) valid3_cnt <= valid3_cnt + 1;
        if (sclk3 != prev_sclk3) begin
            run3 <= 1;
            if (prev_sclk3) begin
                hi_min <= (run3 < hi_min) ? run3 : hi_min;
                hi_max <= (run3 > hi_max) ? run3 : hi_max;
            end else if (rises3 > 0) begin
                lo_min <= (run3 < lo_min) ? run3 : lo_min;
                lo_max <= (run3 > lo_max) ? run3 : lo_max;
            end
            if (sclk3) rises3 <= rises3 + 1;
        end else begin
            run3 <= run3 + 1;
        end
        if (prev_cs3 && !cs3) begin
            hi_min <= 1000; hi_max <= 0; lo_min <= 1000; lo_max <= 0; rises3 <= 0;
        end
    end

    // One go pulse and a full frame; called at a negedge with adc_go low the cycle before.
    // Returns at the negedge of the cycle after adc_valid.
    task automatic run_frame(input logic [3:0] chan, input logic [9:0] res,
                             input logic [15:0] exp_cmd, input string tag);
        int cyc, f0, v0, c0;
        adc_result = res;
        f0 = frame_cnt; v0 = valid_cnt; c0 = cs_low_tot;
        adc_chan = chan;
        adc_go   = 1'b1;
        @(negedge clk3p2M);
        adc_go   = 1'b0;
        adc_chan = 4'($urandom);
        cyc = 1;
        while (!adc_valid && cyc < 4 * LAT) begin
            @(negedge clk3p2M);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        check({tag, " adc_in"}, 32'(adc_in), 32'(res));
        @(negedge clk3p2M);
        check({tag, " valid_single_pulse"}, 32'(adc_valid), 32'd0);
        check({tag, " busy_drops"}, 32'(adc_busy), 32'd0);
        check({tag, " mosi_cmd"}, 32'(mosi_cap), 32'(exp_cmd));
        check({tag, " cs_low_cycles"}, 32'(cs_low_tot - c0), 32'(CS_LOW));
        check({tag, " valid_count"}, 32'(valid_cnt - v0), 32'd1);
        check({tag, " frame_count"}, 32'(frame_cnt - f0), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  chan;
        logic [9:0]  res;
        logic [15:0] exp_cmd;
        logic [9:0]  exp_in;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [9:0] ch_val[16];
        int         cyc, f0, v0, c3, v3;

        vecs[0] = '{chan: 4'd5,  res: 10'h2A5, exp_cmd: 16'hD400, exp_in: 10'h2A5};
        vecs[1] = '{chan: 4'd15, res: 10'h3FF, exp_cmd: 16'hFC00, exp_in: 10'h3FF};
        vecs[2] = '{chan: 4'd0,  res: 10'h000, exp_cmd: 16'hC000, exp_in: 10'h000};
        vecs[3] = '{chan: 4'd10, res: 10'h155, exp_cmd: 16'hE800, exp_in: 10'h155};
        vecs[4] = '{chan: 4'd3,  res: 10'h2AA, exp_cmd: 16'hCC00, exp_in: 10'h2AA};

        // Reset state
        repeat (3) @(negedge clk3p2M);
        check("rst adc_in", 32'(adc_in), 32'd0);
        check("rst adc_valid", 32'(adc_valid), 32'd0);
        check("rst adc_busy", 32'(adc_busy), 32'd0);
        check("rst adc_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst adc_sclk", 32'(adc_sclk), 32'd0);
        check("rst adc_mosi", 32'(adc_mosi), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk3p2M);
        check("post-rst idle cs_n", 32'(adc_cs_n), 32'd1);

        // Reset during SHIFT bit 8, go held high across reset release
        adc_result = 10'h155; adc_chan = 4'd3; adc_go = 1'b1;
        @(negedge clk3p2M);
        adc_go = 1'b0;
        repeat (17) @(negedge clk3p2M);
        check("pre-abort cs_n low", 32'(adc_cs_n), 32'd0);
        adc_go  = 1'b1;
        reset_n = 1'b0;
        #1;
        check("abort cs_n", 32'(adc_cs_n), 32'd1);
        check("abort sclk", 32'(adc_sclk), 32'd0);
        check("abort valid", 32'(adc_valid), 32'd0);
        check("abort busy", 32'(adc_busy), 32'd0);
        check("abort adc_in", 32'(adc_in), 32'd0);
        f0 = frame_cnt; v0 = valid_cnt;
        repeat (3) @(negedge clk3p2M);
        reset_n = 1'b1;
        repeat (20) @(negedge clk3p2M);
        #1;
        check("held go no frame", 32'(frame_cnt - f0), 32'd0);
        check("held go no valid", 32'(valid_cnt - v0), 32'd0);
        check("held go adc_in", 32'(adc_in), 32'd0);
        adc_go = 1'b0;
        @(negedge clk3p2M);
        run_frame(4'd3, 10'h155, 16'hCC00, "after_reset");

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].chan, vecs[i].res, vecs[i].exp_cmd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table adc_in", i), 32'(adc_in), 32'(vecs[i].exp_in));
        end

        // Second go edge mid-frame is ignored, chan change does not alter MOSI
        f0 = frame_cnt; v0 = valid_cnt;
        adc_result = 10'h1C3; adc_chan = 4'd9; adc_go = 1'b1;
        @(negedge clk3p2M);
        adc_go = 1'b0;
        cyc = 1;
        while (!adc_valid && cyc < 4 * LAT) begin
            @(negedge clk3p2M);
            cyc++;
            if (cyc == 10) begin
                check("busy mid-frame", 32'(adc_busy), 32'd1);
                adc_go = 1'b1; adc_chan = 4'd6;
            end
            if (cyc == 11) adc_go = 1'b0;
        end
        check("busy latency", 32'(cyc), 32'(LAT));
        check("busy adc_in", 32'(adc_in), 32'h1C3);
        @(negedge clk3p2M);
        check("busy drops", 32'(adc_busy), 32'd0);
        repeat (50) @(negedge clk3p2M);
        #1;
        check("busy frame count", 32'(frame_cnt - f0), 32'd1);
        check("busy valid count", 32'(valid_cnt - v0), 32'd1);
        check("busy mosi", 32'(mosi_cap), 32'hE400);

        // go held high for 50 cycles: one frame only
        @(negedge clk3p2M);
        f0 = frame_cnt; v0 = valid_cnt;
        adc_result = 10'h0F0; adc_chan = 4'd12; adc_go = 1'b1;
        repeat (50) @(negedge clk3p2M);
        adc_go = 1'b0;
        repeat (60) @(negedge clk3p2M);
        #1;
        check("level frame count", 32'(frame_cnt - f0), 32'd1);
        check("level valid count", 32'(valid_cnt - v0), 32'd1);
        check("level adc_in", 32'(adc_in), 32'h0F0);
        check("level mosi", 32'(mosi_cap), 32'hF000);

        // Updater sweep: go raised the cycle after each valid
        @(negedge clk3p2M);
        for (int i = 0; i < 16; i++) ch_val[i] = 10'($urandom);
        for (int ch = 0; ch < 16; ch++) begin
            run_frame(4'(ch), ch_val[ch], {2'b11, 4'(ch), 10'b0}, $sformatf("sweep%0d", ch));
            if (ch > 0) check($sformatf("sweep%0d cs_gap", ch), 32'(gap_last >= CH), 32'd1);
        end

        // Random channels, results and idle gaps
        for (int n = 0; n < 20; n++) begin
            logic [3:0] c;
            logic [9:0] r;
            c = 4'($urandom);
            r = 10'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk3p2M);
            run_frame(c, r, {2'b11, c, 10'b0}, $sformatf("rand%0d", n));
        end

        // SCLK_DIV=3 instance
        @(negedge clk3p2M);
        c3 = cs3_low_tot; v3 = valid3_cnt;
        chan3 = 4'd7; go3 = 1'b1;
        @(negedge clk3p2M);
        go3 = 1'b0;
        cyc = 1;
        check("div3 first mosi", 32'(mosi3), 32'd1);
        check("div3 busy", 32'(busy3), 32'd1);
        while (!valid3 && cyc < 4 * LAT3) begin
            @(negedge clk3p2M);
            cyc++;
        end
        check("div3 latency", 32'(cyc), 32'(LAT3));
        check("div3 adc_in", 32'(in3), 32'h3FF);
        @(negedge clk3p2M);
        #1;
        check("div3 cs_low_cycles", 32'(cs3_low_tot - c3), 32'(SD3 * (1 + 2 * FB)));
        check("div3 valid count", 32'(valid3_cnt - v3), 32'd1);
        check("div3 sclk rises", 32'(rises3), 32'(FB));
        check("div3 high min", 32'(hi_min), 32'(SD3));
        check("div3 high max", 32'(hi_max), 32'(SD3));
        check("div3 low min", 32'(lo_min), 32'(SD3));
        check("div3 low max", 32'(lo_max), 32'(SD3));

        check("adc_in only changes with valid", 32'(in_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "time limit");
    end
endmodule
